// File: rtl/scoot_arena_if.sv
// rtl/scoot_arena_if.sv - move command / sensor handshake bundle between bot and arena
interface scoot_arena_if;
    logic move_valid;
    logic move_ready;
    logic mUp;
    logic mRight;
    logic mDown;
    logic mLeft;
    logic lUp;
    logic lRight;
    logic lDown;
    logic lLeft;
    logic sense_valid;
    logic picked;

    modport master (
        output move_valid, mUp, mRight, mDown, mLeft,
        input  move_ready, lUp, lRight, lDown, lLeft, sense_valid, picked
    );

    modport slave (
        input  move_valid, mUp, mRight, mDown, mLeft,
        output move_ready, lUp, lRight, lDown, lLeft, sense_valid, picked
    );
endinterface

// File: rtl/scoot_arena.sv
// rtl/scoot_arena.sv - toroidal pellet arena: loads a grid, senses neighbours, applies bot moves
module scoot_arena #(
    parameter int                WIDTH     = 10,
    parameter int                HEIGHT    = 10,
    parameter int                NUM_STEPS = 100,
    parameter logic [HEIGHT-1:0] INIT_COL  = 10'b0010101001
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    scoot_arena_if.slave       bus,
    output logic [7:0]         pos_x,
    output logic [7:0]         pos_y,
    output logic [7:0]         score,
    output logic [7:0]         step_count,
    output logic               done
);
    typedef enum logic [2:0] {IDLE, LOAD, SENSE, WAIT_MOVE, MOVE, DONE} state_t;

    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [7:0] X_MAX = 8'(WIDTH - 1);
    localparam logic [7:0] Y_MAX = 8'(HEIGHT - 1);
    localparam logic [7:0] X_MID = 8'(WIDTH / 2);
    localparam logic [7:0] Y_MID = 8'(HEIGHT / 2);
    localparam logic [7:0] STEPS = 8'(NUM_STEPS);

    state_t            state;
    logic [HEIGHT-1:0] grid [WIDTH];
    logic [7:0]        loadIdx;
    logic              cmdUp, cmdRight, cmdDown, cmdLeft;
    logic              moveReady, senseValid;
    logic              lUpR, lRightR, lDownR, lLeftR;

    function automatic logic [7:0] incWrap(input logic [7:0] v, input logic [7:0] maxv);
        return (v == maxv) ? 8'd0 : v + 8'd1;
    endfunction

    function automatic logic [7:0] decWrap(input logic [7:0] v, input logic [7:0] maxv);
        return (v == 8'd0) ? maxv : v - 8'd1;
    endfunction

    logic [7:0] xPlus, xMinus, yPlus, yMinus, nextX, nextY;
    logic [XW-1:0] xi;
    logic [YW-1:0] yi;
    logic          curCell;

    assign xPlus  = incWrap(pos_x, X_MAX);
    assign xMinus = decWrap(pos_x, X_MAX);
    assign yPlus  = incWrap(pos_y, Y_MAX);
    assign yMinus = decWrap(pos_y, Y_MAX);
    assign xi     = pos_x[XW-1:0];
    assign yi     = pos_y[YW-1:0];
    assign curCell = grid[xi][yi];

    // Opposing command bits cancel, so only a lone direction moves the bot.
    always_comb begin
        nextX = pos_x;
        nextY = pos_y;
        if (cmdRight && !cmdLeft)      nextX = xPlus;
        else if (cmdLeft && !cmdRight) nextX = xMinus;
        if (cmdUp && !cmdDown)         nextY = yPlus;
        else if (cmdDown && !cmdUp)    nextY = yMinus;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            for (int i = 0; i < WIDTH; i++) grid[i] <= '0;
            loadIdx    <= 8'd0;
            pos_x      <= X_MID;
            pos_y      <= Y_MID;
            score      <= 8'd0;
            step_count <= 8'd0;
            done       <= 1'b0;
            cmdUp      <= 1'b0;
            cmdRight   <= 1'b0;
            cmdDown    <= 1'b0;
            cmdLeft    <= 1'b0;
            moveReady  <= 1'b0;
            senseValid <= 1'b0;
            lUpR       <= 1'b0;
            lRightR    <= 1'b0;
            lDownR     <= 1'b0;
            lLeftR     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        score      <= 8'd0;
                        step_count <= 8'd0;
                        pos_x      <= X_MID;
                        pos_y      <= Y_MID;
                        done       <= 1'b0;
                        loadIdx    <= 8'd0;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    grid[loadIdx[XW-1:0]] <= INIT_COL;
                    loadIdx <= loadIdx + 8'd1;
                    if (loadIdx == X_MAX) state <= SENSE;
                end
                SENSE: begin
                    if (curCell) begin
                        grid[xi][yi] <= 1'b0;
                        if (score != 8'hFF) score <= score + 8'd1;
                    end
                    lUpR       <= grid[xi][yPlus[YW-1:0]];
                    lDownR     <= grid[xi][yMinus[YW-1:0]];
                    lRightR    <= grid[xPlus[XW-1:0]][yi];
                    lLeftR     <= grid[xMinus[XW-1:0]][yi];
                    moveReady  <= 1'b1;
                    senseValid <= 1'b1;
                    state      <= WAIT_MOVE;
                end
                WAIT_MOVE: begin
                    if (bus.move_valid && moveReady) begin
                        cmdUp      <= bus.mUp;
                        cmdRight   <= bus.mRight;
                        cmdDown    <= bus.mDown;
                        cmdLeft    <= bus.mLeft;
                        moveReady  <= 1'b0;
                        senseValid <= 1'b0;
                        state      <= MOVE;
                    end
                end
                MOVE: begin
                    pos_x      <= nextX;
                    pos_y      <= nextY;
                    step_count <= step_count + 8'd1;
                    if ((step_count + 8'd1) == STEPS) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= SENSE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // picked reflects the cell being consumed during the SENSE cycle itself.
    assign bus.picked      = (state == SENSE) && curCell;
    assign bus.move_ready  = moveReady;
    assign bus.sense_valid = senseValid;
    assign bus.lUp         = lUpR;
    assign bus.lRight      = lRightR;
    assign bus.lDown       = lDownR;
    assign bus.lLeft       = lLeftR;
endmodule
